// File: rtl/ladybird_ifetch_buffer.sv
// ladybird_ifetch_buffer: sequential instruction prefetch FIFO between core fetch port and memory.
module ladybird_ifetch_buffer #(
  parameter int XLEN            = 32,
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            anrst,
  input  logic            core_req,
  input  logic [XLEN-1:0] core_addr,
  output logic            core_gnt,
  output logic [XLEN-1:0] core_data,
  input  logic            fence,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + MAX_OUTSTANDING + 1) + 1;
  typedef enum logic {IDLE, STREAM} state_e;
  state_e state_q, state_d;
  logic [XLEN-1:0] fifo_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d, out_q, out_d, disc_q, disc_d;
  logic pend_q, pend_d, gnt_q, gnt_d;
  logic [XLEN-1:0] pend_addr_q, pend_addr_d, fetch_q, fetch_d, head_q, head_d, data_q, data_d;
  logic active, streaming, match, eval, hit, wait_ok, miss, flush;
  logic rv_drop, rv_push, push, accept;
  logic [XLEN-1:0] addr, addr_al;
  always_comb begin
    active    = pend_q | core_req;
    addr      = pend_q ? pend_addr_q : core_addr;
    addr_al   = addr & ~XLEN'(3);
    streaming = state_q == STREAM;
    match     = ((addr ^ head_q) & ~XLEN'(3)) == '0;
    // No evaluation in a grant cycle, so grants are never back to back.
    eval      = active & ~gnt_q & ~fence;
    hit       = eval & streaming & match & (count_q != '0);
    // Head word is in flight or about to issue, since fetch_addr==head_addr when nothing is buffered.
    wait_ok   = streaming & match & (count_q == '0);
    miss      = eval & ~hit & ~wait_ok;
    flush     = fence | miss;
    rv_drop   = mem_rvalid & (disc_q != '0);
    rv_push   = mem_rvalid & (disc_q == '0) & (out_q != '0);
    push      = rv_push & ~flush;
    mem_req   = streaming & (count_q + out_q < CW'(DEPTH)) &
                (disc_q + out_q < CW'(MAX_OUTSTANDING)) & ~flush;
    mem_addr  = fetch_q;
    accept    = mem_req & mem_ready;
    state_d     = fence ? IDLE : miss ? STREAM : state_q;
    fetch_d     = miss ? addr_al : accept ? fetch_q + XLEN'(4) : fetch_q;
    head_d      = miss ? addr_al : hit ? head_q + XLEN'(4) : head_q;
    out_d       = flush ? '0 : out_q + CW'(accept) - CW'(rv_push);
    disc_d      = flush ? disc_q - CW'(rv_drop) + out_q - CW'(rv_push) : disc_q - CW'(rv_drop);
    count_d     = flush ? '0 : count_q + CW'(push) - CW'(hit);
    rd_d        = flush ? '0 : rd_q + AW'(hit);
    wr_d        = flush ? '0 : wr_q + AW'(push);
    pend_d      = ~fence & ~hit & active;
    pend_addr_d = (core_req & ~pend_q) ? core_addr : pend_addr_q;
    gnt_d       = hit;
    data_d      = hit ? fifo_q[rd_q] : data_q;
  end
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      state_q     <= IDLE;
      rd_q        <= '0;
      wr_q        <= '0;
      count_q     <= '0;
      out_q       <= '0;
      disc_q      <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      fetch_q     <= '0;
      head_q      <= '0;
      gnt_q       <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      count_q     <= count_d;
      out_q       <= out_d;
      disc_q      <= disc_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      fetch_q     <= fetch_d;
      head_q      <= head_d;
      gnt_q       <= gnt_d;
      data_q      <= data_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_q] <= mem_rdata;
  end
  assign core_gnt  = gnt_q;
  assign core_data = data_q;
endmodule
